// File: rtl/rf_pkg.sv
// Shared RV32I register-file constants, imported by the regfile, decode and hazard units.
package rf_pkg;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);
  localparam logic [AW-1:0] REG_ZERO = '0;
endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: set at issue, cleared at writeback, with set taking priority.
module rf_scoreboard
  import rf_pkg::REG_ZERO;
#(
  parameter int NREGS = rf_pkg::NREGS,
  parameter int NRD   = 2,
  parameter int NWR   = 1,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD*AW-1:0] raddr,
  input  logic [NWR-1:0]    we,
  input  logic [NWR*AW-1:0] waddr,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_rd,
  output logic [NRD-1:0]    rbusy,
  output logic [NREGS-1:0]  busy_vec
);
  localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);

  logic [NRD-1:0][AW-1:0] ra;
  logic [NWR-1:0][AW-1:0] wa;
  logic [NREGS-1:0]       busy_d, busy_q;

  assign ra = raddr;
  assign wa = waddr;

  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NWR; j++)
      if (we[j]) busy_d[wa[j]] = 1'b0;
    // Applied after the clears so a new producer keeps the register busy.
    if (issue_valid && issue_rd != ZERO) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // Looked up from stored state only; the hazard unit handles forwarding.
  always_comb begin
    rbusy = '0;
    for (int i = 0; i < NRD; i++) rbusy[i] = busy_q[ra[i]];
  end

  assign busy_vec = busy_q;
endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass and busy scoreboard.
module regfile_mp
  import rf_pkg::REG_ZERO;
#(
  parameter int XLEN   = rf_pkg::XLEN,
  parameter int NREGS  = rf_pkg::NREGS,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter bit BYPASS = 1'b1,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_rd,
  output logic [NREGS-1:0]    busy_vec
);
  localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);

  logic [NRD-1:0][AW-1:0]   ra;
  logic [NRD-1:0][XLEN-1:0] rd;
  logic [NWR-1:0][AW-1:0]   wa;
  logic [NWR-1:0][XLEN-1:0] wd;

  logic [XLEN-1:0] regs_d [NREGS];
  logic [XLEN-1:0] regs_q [NREGS];

  assign ra    = raddr;
  assign wa    = waddr;
  assign wd    = wdata;
  assign rdata = rd;

  // Ascending port order lets the higher-numbered port win a same-address write.
  always_comb begin
    regs_d = regs_q;
    for (int j = 0; j < NWR; j++)
      if (we[j] && wa[j] != ZERO) regs_d[wa[j]] = wd[j];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // x0 storage is never written, so the plain lookup already returns zero for it.
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rd[i] = regs_q[ra[i]];
      if (BYPASS && rst_n && ra[i] != ZERO)
        for (int j = 0; j < NWR; j++)
          if (we[j] && wa[j] == ra[i]) rd[i] = wd[j];
    end
  end

  rf_scoreboard #(
    .NREGS(NREGS),
    .NRD  (NRD),
    .NWR  (NWR),
    .AW   (AW)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .raddr      (raddr),
    .we         (we),
    .waddr      (waddr),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .rbusy      (rbusy),
    .busy_vec   (busy_vec)
  );
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: dual-write bypassing instance (a) and single-write non-bypassing instance (b).
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  logic [9:0]  a_raddr;
  logic [63:0] a_rdata;
  logic [1:0]  a_rbusy;
  logic [1:0]  a_we;
  logic [9:0]  a_waddr;
  logic [63:0] a_wdata;
  logic        a_iv;
  logic [4:0]  a_ird;
  logic [31:0] a_busy;

  logic [9:0]  b_raddr;
  logic [63:0] b_rdata;
  logic [1:0]  b_rbusy;
  logic [0:0]  b_we;
  logic [4:0]  b_waddr;
  logic [31:0] b_wdata;
  logic        b_iv;
  logic [4:0]  b_ird;
  logic [31:0] b_busy;

  always #5 clk = ~clk;

  regfile_mp #(.NRD(2), .NWR(2), .BYPASS(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .raddr(a_raddr), .rdata(a_rdata), .rbusy(a_rbusy),
    .we(a_we), .waddr(a_waddr), .wdata(a_wdata), .issue_valid(a_iv),
    .issue_rd(a_ird), .busy_vec(a_busy)
  );

  regfile_mp #(.NRD(2), .NWR(1), .BYPASS(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .raddr(b_raddr), .rdata(b_rdata), .rbusy(b_rbusy),
    .we(b_we), .waddr(b_waddr), .wdata(b_wdata), .issue_valid(b_iv),
    .issue_rd(b_ird), .busy_vec(b_busy)
  );

  task automatic idle();
    a_raddr = '0; a_we = '0; a_waddr = '0; a_wdata = '0; a_iv = 1'b0; a_ird = '0;
    b_raddr = '0; b_we = '0; b_waddr = '0; b_wdata = '0; b_iv = 1'b0; b_ird = '0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    a_we = 2'b11; a_waddr = {5'd1, 5'd1}; a_wdata = {32'd77, 32'd66};
    a_raddr = {5'd1, 5'd1}; a_iv = 1'b1; a_ird = 5'd1;
    @(posedge clk); #1;
    tests++; if (a_rdata !== 64'd0) begin fails++; $display("FAIL reset_rdata got %h want 0", a_rdata); end
    tests++; if (a_busy !== 32'd0) begin fails++; $display("FAIL reset_busy got %h want 0", a_busy); end
    tests++; if (a_rbusy !== 2'b00) begin fails++; $display("FAIL reset_rbusy got %b want 00", a_rbusy); end
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    a_raddr = {5'd1, 5'd1};
    #1;
    tests++; if (a_rdata !== 64'd0) begin fails++; $display("FAIL reset_write_ignored got %h want 0", a_rdata); end
  endtask

  task automatic test_basic_rw();
    @(negedge clk); idle();
    a_we = 2'b01; a_waddr[4:0] = 5'd1; a_wdata[31:0] = 32'd5;
    b_we = 1'b1;  b_waddr = 5'd1;      b_wdata = 32'd5;
    @(posedge clk);
    @(negedge clk); idle();
    a_raddr = {5'd0, 5'd1}; b_raddr = {5'd0, 5'd1};
    #1;
    tests++; if (a_rdata[31:0] !== 32'd5) begin fails++; $display("FAIL basic_a_x1 got %0d want 5", a_rdata[31:0]); end
    tests++; if (a_rdata[63:32] !== 32'd0) begin fails++; $display("FAIL basic_a_x0 got %0d want 0", a_rdata[63:32]); end
    tests++; if (b_rdata[31:0] !== 32'd5) begin fails++; $display("FAIL basic_b_x1 got %0d want 5", b_rdata[31:0]); end
  endtask

  task automatic test_x0();
    @(negedge clk); idle();
    a_we = 2'b01; a_waddr[4:0] = 5'd0; a_wdata[31:0] = 32'd123;
    a_iv = 1'b1; a_ird = 5'd0;
    #1;
    tests++; if (a_rdata[31:0] !== 32'd0) begin fails++; $display("FAIL x0_no_bypass got %0d want 0", a_rdata[31:0]); end
    @(posedge clk);
    @(negedge clk); idle();
    #1;
    tests++; if (a_rdata[31:0] !== 32'd0) begin fails++; $display("FAIL x0_read got %0d want 0", a_rdata[31:0]); end
    tests++; if (a_busy !== 32'd0) begin fails++; $display("FAIL x0_busy got %h want 0", a_busy); end
  endtask

  task automatic test_bypass();
    @(negedge clk); idle();
    a_we = 2'b01; a_waddr[4:0] = 5'd2; a_wdata[31:0] = 32'd7;
    b_we = 1'b1;  b_waddr = 5'd2;      b_wdata = 32'd7;
    @(posedge clk);
    @(negedge clk); idle();
    a_we = 2'b01; a_waddr[4:0] = 5'd2; a_wdata[31:0] = 32'd9; a_raddr = {5'd1, 5'd2};
    b_we = 1'b1;  b_waddr = 5'd2;      b_wdata = 32'd9;       b_raddr = {5'd1, 5'd2};
    #1;
    tests++; if (a_rdata[31:0] !== 32'd9) begin fails++; $display("FAIL bypass_on got %0d want 9", a_rdata[31:0]); end
    tests++; if (a_rdata[63:32] !== 32'd5) begin fails++; $display("FAIL bypass_other_port got %0d want 5", a_rdata[63:32]); end
    tests++; if (b_rdata[31:0] !== 32'd7) begin fails++; $display("FAIL bypass_off got %0d want 7", b_rdata[31:0]); end
    @(posedge clk);
    @(negedge clk); idle();
    a_raddr = {5'd0, 5'd2}; b_raddr = {5'd0, 5'd2};
    #1;
    tests++; if (a_rdata[31:0] !== 32'd9) begin fails++; $display("FAIL bypass_a_stored got %0d want 9", a_rdata[31:0]); end
    tests++; if (b_rdata[31:0] !== 32'd9) begin fails++; $display("FAIL bypass_b_stored got %0d want 9", b_rdata[31:0]); end
  endtask

  task automatic test_dual_write();
    @(negedge clk); idle();
    a_we = 2'b11; a_waddr = {5'd3, 5'd3}; a_wdata = {32'h5555, 32'hAAAA};
    a_raddr = {5'd3, 5'd3};
    #1;
    tests++; if (a_rdata !== {32'h5555, 32'h5555}) begin fails++; $display("FAIL dual_bypass got %h want 5555 on both", a_rdata); end
    @(posedge clk);
    @(negedge clk); idle();
    a_we = 2'b11; a_waddr = {5'd9, 5'd8}; a_wdata = {32'h22, 32'h11};
    a_raddr = {5'd0, 5'd3};
    #1;
    tests++; if (a_rdata[31:0] !== 32'h5555) begin fails++; $display("FAIL dual_conflict got %h want 5555", a_rdata[31:0]); end
    @(posedge clk);
    @(negedge clk); idle();
    a_raddr = {5'd9, 5'd8};
    #1;
    tests++; if (a_rdata !== {32'h22, 32'h11}) begin fails++; $display("FAIL dual_distinct got %h want 22/11", a_rdata); end
  endtask

  task automatic test_scoreboard();
    @(negedge clk); idle();
    a_iv = 1'b1; a_ird = 5'd4; a_raddr = {5'd1, 5'd4};
    #1;
    tests++; if (a_rbusy !== 2'b00) begin fails++; $display("FAIL sb_pre_issue got %b want 00", a_rbusy); end
    @(posedge clk);
    @(negedge clk); idle();
    a_raddr = {5'd1, 5'd4};
    #1;
    tests++; if (a_busy !== 32'h10) begin fails++; $display("FAIL sb_issue got %h want 10", a_busy); end
    tests++; if (a_rbusy !== 2'b01) begin fails++; $display("FAIL sb_rbusy got %b want 01", a_rbusy); end
    a_we = 2'b01; a_waddr[4:0] = 5'd4; a_wdata[31:0] = 32'd44;
    #1;
    tests++; if (a_rbusy !== 2'b01) begin fails++; $display("FAIL sb_rbusy_unbypassed got %b want 01", a_rbusy); end
    tests++; if (a_rdata[31:0] !== 32'd44) begin fails++; $display("FAIL sb_wb_bypass got %0d want 44", a_rdata[31:0]); end
    @(posedge clk);
    @(negedge clk); idle();
    #1;
    tests++; if (a_busy !== 32'h0) begin fails++; $display("FAIL sb_clear got %h want 0", a_busy); end
    a_iv = 1'b1; a_ird = 5'd4;
    @(posedge clk);
    @(negedge clk); idle();
    a_we = 2'b10; a_waddr[9:5] = 5'd4; a_wdata[63:32] = 32'd45;
    a_iv = 1'b1; a_ird = 5'd4;
    @(posedge clk);
    @(negedge clk); idle();
    #1;
    tests++; if (a_busy !== 32'h10) begin fails++; $display("FAIL sb_set_wins got %h want 10", a_busy); end
    a_iv = 1'b1; a_ird = 5'd4;
    a_we = 2'b01; a_waddr[4:0] = 5'd6; a_wdata[31:0] = 32'd66;
    @(posedge clk);
    @(negedge clk); idle();
    #1;
    tests++; if (a_busy !== 32'h10) begin fails++; $display("FAIL sb_reissue_nonbusy_wb got %h want 10", a_busy); end
  endtask

  task automatic test_async_reset();
    @(negedge clk); idle();
    a_we = 2'b01; a_waddr[4:0] = 5'd5; a_wdata[31:0] = 32'h1234;
    a_iv = 1'b1; a_ird = 5'd5;
    @(posedge clk);
    @(negedge clk); idle();
    a_raddr = {5'd4, 5'd5};
    #1;
    tests++; if (a_busy !== 32'h30) begin fails++; $display("FAIL ar_busy_pre got %h want 30", a_busy); end
    tests++; if (a_rdata[31:0] !== 32'h1234) begin fails++; $display("FAIL ar_x5_pre got %h want 1234", a_rdata[31:0]); end
    tests++; if (a_rbusy !== 2'b11) begin fails++; $display("FAIL ar_rbusy_pre got %b want 11", a_rbusy); end
    #1 rst_n = 1'b0;
    #1;
    tests++; if (a_busy !== 32'h0) begin fails++; $display("FAIL ar_busy_async got %h want 0", a_busy); end
    tests++; if (a_rdata !== 64'd0) begin fails++; $display("FAIL ar_rdata_async got %h want 0", a_rdata); end
    tests++; if (a_rbusy !== 2'b00) begin fails++; $display("FAIL ar_rbusy_async got %b want 00", a_rbusy); end
    a_we = 2'b01; a_waddr[4:0] = 5'd7; a_wdata[31:0] = 32'hFF;
    b_we = 1'b1;  b_waddr = 5'd7;      b_wdata = 32'hFF;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    a_raddr = {5'd7, 5'd5}; b_raddr = {5'd2, 5'd7};
    #1;
    tests++; if (a_rdata !== 64'd0) begin fails++; $display("FAIL ar_a_after got %h want 0", a_rdata); end
    tests++; if (b_rdata !== 64'd0) begin fails++; $display("FAIL ar_b_after got %h want 0", b_rdata); end
  endtask

  initial begin
    test_reset();
    test_basic_rw();
    test_x0();
    test_bypass();
    test_dual_write();
    test_scoreboard();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the RV32I pipelined core. It is the successor to the single-write, two-read regfile.
- Adds configurable read/write port counts, optional write-to-read bypass, and an integrated busy-bit scoreboard for decode-stage hazard detection.
- Sits between decode (read/issue) and writeback (write); x0 is hardwired to zero.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers (power of two, >=2).
- NRD, 2, number of read ports (1..4).
- NWR, 1, number of write ports (1..2).
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads; 0 = reads return stored value.
- AW, $clog2(NREGS), register address width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- raddr  input  NRD*AW  read addresses, port i at [i*AW +: AW].
- rdata  output  NRD*XLEN  read data, port i at [i*XLEN +: XLEN].
- rbusy  output  NRD  busy bit of register addressed by read port i.
- we  input  NWR  write enables.
- waddr  input  NWR*AW  write addresses.
- wdata  input  NWR*XLEN  write data.
- issue_valid  input  1  instruction with destination issued this cycle.
- issue_rd  input  AW  destination register of the issued instruction.
- busy_vec  output  NREGS  full scoreboard, bit 0 always 0.

Behaviour:
- Clock and reset: one clock, clk, rising edge. Reset is rst_n, asynchronous and active-low. While rst_n=0, all registers=0 and all busy bits=0 immediately; writes and issues are ignored; bypass is disabled, so rdata=0, rbusy=0 and busy_vec=0.
- Reads: combinational, zero latency. rdata[i] = regs[raddr[i]]; raddr=0 always returns 0.
- Bypass (BYPASS=1, rst_n=1): if any we[j] && waddr[j]==raddr[i] && raddr[i]!=0, rdata[i] = wdata[j]. With two matching write ports, port 1 wins.
- Writes: on posedge clk, regs[waddr[j]] <= wdata[j] when we[j] && waddr[j]!=0. Writes to x0 are discarded. If both ports write the same address, port 1 wins.
- Scoreboard, evaluated on posedge clk:
  - Clear: busy[waddr[j]] <= 0 for each enabled write.
  - Set: busy[issue_rd] <= 1 when issue_valid && issue_rd!=0.
  - Same-cycle clear and set to the same register: set wins, so the register stays busy (new producer in flight).
  - Issue to an already-busy register: stays 1 (no count; the pipeline guarantees in-order writeback per register).
  - Write to a non-busy register: legal, busy stays 0.
- rbusy[i] = busy[raddr[i]] from the current stored state. It is not bypassed by same-cycle writeback; the hazard unit combines it with forwarding.
- Reset mid-operation: pending issues are lost, and all busy bits clear asynchronously at rst_n fall.
- Address out of range: cannot occur (NREGS is a power of two).

Decomposition:
- Shared package rf_pkg: XLEN, NREGS, AW constants, and the REG_ZERO = 0 address constant. The core's decode and hazard units import the same package.
- One natural sub-module: rf_scoreboard (busy-bit array with set/clear priority, busy_vec and rbusy lookup).
- Storage, write logic and bypass mux stay in regfile_mp.

Test Plan:
- Reset and basic write/read: assert rst_n=0, then release. Write x1=5 (we[0], waddr=1) at posedge. Next cycle raddr[0]=1 -> rdata[0]=5; raddr[1]=0 -> rdata[1]=0.
- x0 protection: write x0=123, read x0 -> 0. Issue to rd=0 -> busy_vec[0]=0.
- Bypass, with BYPASS=1: x2 holds 7; same cycle we=1, waddr=2, wdata=9, raddr[0]=2 -> rdata[0]=9 before the edge, stored 9 after. Same stimulus with BYPASS=0 -> rdata[0]=7 before the edge.
- Dual write conflict, with NWR=2: port0 writes x3=0xAAAA and port1 writes x3=0x5555 in the same cycle -> x3=0x5555. The bypass read also shows 0x5555.
- Scoreboard:
  - Issue rd=4 -> busy_vec[4]=1, rbusy=1 when raddr=4.
  - Writeback x4 -> busy cleared next cycle.
  - Writeback x4 with simultaneous issue rd=4 -> busy stays 1.
- Async reset mid-operation: busy_vec=0x00000030 and x5=0x1234, drop rst_n between clock edges -> busy_vec=0 and rdata(x5)=0 without waiting for a clock edge. Writes during reset are ignored.
